// File: rtl/llc_fwd_seq.sv
// LLC forward-message sequencer: serialises one command per L2 target.
// Optional LLC_FWD_SEQ_STATS_EN adds fwd_sent_cnt / fwd_stall_cnt.
module llc_fwd_seq #(
    parameter int N_L2      = 16,
    parameter int ID_BITS   = 4,
    parameter int ADDR_BITS = 28,
    parameter int MSG_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [MSG_BITS-1:0]  cmd_coh_msg,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [ID_BITS-1:0]   cmd_req_id,
    input  logic [ID_BITS-1:0]   cmd_dest_id,
    input  logic [N_L2-1:0]      cmd_sharers,
    output logic                 fwd_out_valid,
    input  logic                 fwd_out_ready,
    output logic [MSG_BITS-1:0]  fwd_out_coh_msg,
    output logic [ADDR_BITS-1:0] fwd_out_addr,
    output logic [ID_BITS-1:0]   fwd_out_req_id,
    output logic [ID_BITS-1:0]   fwd_out_dest_id,
`ifdef LLC_FWD_SEQ_STATS_EN
    output logic [15:0]          fwd_sent_cnt,
    output logic [15:0]          fwd_stall_cnt,
`endif
    output logic                 done,
    output logic [ID_BITS:0]     inv_cnt
);

    localparam logic [MSG_BITS-1:0] FWD_GETS    = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] FWD_GETM    = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] FWD_INV     = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] FWD_PUTACK  = MSG_BITS'(3);
    localparam logic [MSG_BITS-1:0] FWD_INV_LLC = MSG_BITS'(4);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t              state;
    logic [N_L2-1:0]     rem;
    logic [ID_BITS:0]    cnt;

    logic [N_L2-1:0]     acc_rem;
    logic [N_L2-1:0]     rem_nxt;
    logic [ID_BITS:0]    cnt_nxt;
    logic                hs;

    function automatic logic is_inv(input logic [MSG_BITS-1:0] m);
        return (m == FWD_INV) || (m == FWD_INV_LLC);
    endfunction

    function automatic logic [N_L2-1:0] bit_of(input logic [ID_BITS-1:0] id);
        bit_of = '0;
        for (int i = 0; i < N_L2; i++) begin
            if (ID_BITS'(i) == id) bit_of[i] = 1'b1;
        end
    endfunction

    function automatic logic [ID_BITS-1:0] low_idx(input logic [N_L2-1:0] m);
        low_idx = '0;
        for (int i = N_L2 - 1; i >= 0; i--) begin
            if (m[i]) low_idx = ID_BITS'(i);
        end
    endfunction

    // Target set for a new command and the post-handshake bookkeeping.
    always_comb begin
        acc_rem = '0;
        if (is_inv(cmd_coh_msg)) begin
            acc_rem = cmd_sharers & ~bit_of(cmd_req_id);
        end else begin
            acc_rem = bit_of(cmd_dest_id);
        end
        hs      = fwd_out_valid && fwd_out_ready;
        rem_nxt = rem & ~bit_of(fwd_out_dest_id);
        cnt_nxt = cnt;
        if (is_inv(fwd_out_coh_msg)) cnt_nxt = cnt + (ID_BITS+1)'(1);
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cmd_ready       <= 1'b0;
            fwd_out_valid   <= 1'b0;
            fwd_out_coh_msg <= '0;
            fwd_out_addr    <= '0;
            fwd_out_req_id  <= '0;
            fwd_out_dest_id <= '0;
            done            <= 1'b0;
            inv_cnt         <= '0;
            rem             <= '0;
            cnt             <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready       <= 1'b0;
                        fwd_out_coh_msg <= cmd_coh_msg;
                        fwd_out_addr    <= cmd_addr;
                        fwd_out_req_id  <= cmd_req_id;
                        rem             <= acc_rem;
                        cnt             <= '0;
                        if (acc_rem != '0) begin
                            state           <= SEND;
                            fwd_out_valid   <= 1'b1;
                            fwd_out_dest_id <= low_idx(acc_rem);
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            inv_cnt <= '0;
                        end
                    end
                end
                SEND: begin
                    if (hs) begin
                        rem <= rem_nxt;
                        cnt <= cnt_nxt;
                        if (rem_nxt == '0) begin
                            fwd_out_valid <= 1'b0;
                            state         <= DONE;
                            done          <= 1'b1;
                            inv_cnt       <= cnt_nxt;
                        end else begin
                            fwd_out_dest_id <= low_idx(rem_nxt);
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LLC_FWD_SEQ_STATS_EN
    // Saturating handshake and stall counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_sent_cnt  <= '0;
            fwd_stall_cnt <= '0;
        end else begin
            if (hs && fwd_sent_cnt != 16'hFFFF) begin
                fwd_sent_cnt <= fwd_sent_cnt + 16'd1;
            end
            if (fwd_out_valid && !fwd_out_ready &&
                fwd_stall_cnt != 16'hFFFF) begin
                fwd_stall_cnt <= fwd_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_llc_fwd_seq.sv
// Directed bench for llc_fwd_seq.
// Covers multicast, stall, empty mask, full mask, reset abort.
module tb_llc_fwd_seq;

    localparam logic [2:0] M_GETS    = 3'd0;
    localparam logic [2:0] M_GETM    = 3'd1;
    localparam logic [2:0] M_INV     = 3'd2;
    localparam logic [2:0] M_PUTACK  = 3'd3;
    localparam logic [2:0] M_INV_LLC = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        c_valid = 1'b0;
    logic        c_ready;
    logic [2:0]  c_msg = '0;
    logic [27:0] c_addr = '0;
    logic [3:0]  c_req = '0;
    logic [3:0]  c_dest = '0;
    logic [15:0] c_sh = '0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [2:0]  o_msg;
    logic [27:0] o_addr;
    logic [3:0]  o_req;
    logic [3:0]  o_dest;
    logic        done;
    logic [4:0]  inv_cnt;

    logic        w_valid = 1'b0;
    logic        w_cready;
    logic [2:0]  w_msg = '0;
    logic [27:0] w_addr = '0;
    logic [4:0]  w_req = '0;
    logic [4:0]  w_dest = '0;
    logic [15:0] w_sh = '0;
    logic        w_ovalid;
    logic        w_oready = 1'b1;
    logic [2:0]  w_omsg;
    logic [27:0] w_oaddr;
    logic [4:0]  w_oreq;
    logic [4:0]  w_odest;
    logic        w_done;
    logic [5:0]  w_inv;

`ifdef LLC_FWD_SEQ_STATS_EN
    logic [15:0] sent_cnt;
    logic [15:0] stall_cnt;
    logic [15:0] w_sent;
    logic [15:0] w_stall;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    llc_fwd_seq u_dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (c_valid),
        .cmd_ready      (c_ready),
        .cmd_coh_msg    (c_msg),
        .cmd_addr       (c_addr),
        .cmd_req_id     (c_req),
        .cmd_dest_id    (c_dest),
        .cmd_sharers    (c_sh),
        .fwd_out_valid  (o_valid),
        .fwd_out_ready  (o_ready),
        .fwd_out_coh_msg(o_msg),
        .fwd_out_addr   (o_addr),
        .fwd_out_req_id (o_req),
        .fwd_out_dest_id(o_dest),
`ifdef LLC_FWD_SEQ_STATS_EN
        .fwd_sent_cnt   (sent_cnt),
        .fwd_stall_cnt  (stall_cnt),
`endif
        .done           (done),
        .inv_cnt        (inv_cnt)
    );

    llc_fwd_seq #(.ID_BITS(5)) u_wide (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (w_valid),
        .cmd_ready      (w_cready),
        .cmd_coh_msg    (w_msg),
        .cmd_addr       (w_addr),
        .cmd_req_id     (w_req),
        .cmd_dest_id    (w_dest),
        .cmd_sharers    (w_sh),
        .fwd_out_valid  (w_ovalid),
        .fwd_out_ready  (w_oready),
        .fwd_out_coh_msg(w_omsg),
        .fwd_out_addr   (w_oaddr),
        .fwd_out_req_id (w_oreq),
        .fwd_out_dest_id(w_odest),
`ifdef LLC_FWD_SEQ_STATS_EN
        .fwd_sent_cnt   (w_sent),
        .fwd_stall_cnt  (w_stall),
`endif
        .done           (w_done),
        .inv_cnt        (w_inv)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0]  msg,
                            input logic [27:0] addr,
                            input logic [3:0]  req,
                            input logic [3:0]  dest,
                            input logic [15:0] sh);
        int n;
        n = 0;
        while (!c_ready && n < 20) begin
            tick();
            n++;
        end
        if (!c_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
        c_msg   = msg;
        c_addr  = addr;
        c_req   = req;
        c_dest  = dest;
        c_sh    = sh;
        c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
    endtask

    task automatic expect_seq(input string tag,
                              input logic [15:0] m,
                              input int n,
                              input logic [2:0] msg,
                              input logic [3:0] req,
                              input logic [27:0] addr);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                chk({tag, "_valid"}, 32'(o_valid), 32'd1);
                chk({tag, "_dest"}, 32'(o_dest), 32'(i));
                chk({tag, "_msg"}, 32'(o_msg), 32'(msg));
                chk({tag, "_req"}, 32'(o_req), 32'(req));
                chk({tag, "_addr"}, 32'(o_addr), 32'(addr));
                tick();
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_inv_cnt"}, 32'(inv_cnt), 32'(n));
        chk({tag, "_valid_end"}, 32'(o_valid), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_cmd_ready", 32'(c_ready), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_inv_cnt", 32'(inv_cnt), 32'd0);
        chk("rst_dest", 32'(o_dest), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        #11;
        rst = 1'b1;
        tick();
        chk("post_rst_ready", 32'(c_ready), 32'd1);

        send_cmd(M_INV, 28'h0ABCDE1, 4'd0, 4'd0, 16'h00A5);
        expect_seq("inv_a5", 16'h00A4, 3, M_INV, 4'd0, 28'h0ABCDE1);

        o_ready = 1'b0;
        send_cmd(M_GETM, 28'h1234567, 4'd3, 4'd9, 16'hFFFF);
        c_msg   = M_INV;
        c_addr  = 28'hFFFFFFF;
        c_dest  = 4'd1;
        c_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_dest", 32'(o_dest), 32'd9);
            chk("stall_addr", 32'(o_addr), 32'h1234567);
            chk("stall_msg", 32'(o_msg), 32'(M_GETM));
            chk("stall_cready", 32'(c_ready), 32'd0);
            tick();
        end
        c_valid = 1'b0;
        o_ready = 1'b1;
        chk("stall_last_valid", 32'(o_valid), 32'd1);
        tick();
        chk("getm_done", 32'(done), 32'd1);
        chk("getm_inv_cnt", 32'(inv_cnt), 32'd0);
        chk("getm_valid_end", 32'(o_valid), 32'd0);

        send_cmd(M_INV_LLC, 28'h0000042, 4'd4, 4'd0, 16'h0010);
        chk("empty_valid", 32'(o_valid), 32'd0);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_inv_cnt", 32'(inv_cnt), 32'd0);
        tick();

        send_cmd(M_PUTACK, 28'h0000777, 4'd5, 4'd5, 16'h0000);
        expect_seq("self_uni", 16'h0020, 0, M_PUTACK, 4'd5, 28'h0000777);

        send_cmd(M_INV, 28'h0F0F0F0, 4'd0, 4'd0, 16'hFFFF);
        expect_seq("full", 16'hFFFE, 15, M_INV, 4'd0, 28'h0F0F0F0);

        begin
            int n;
            n = 0;
            while (!w_cready && n < 20) begin
                tick();
                n++;
            end
            chk("w_cmd_ready", 32'(w_cready), 32'd1);
            w_msg   = M_INV;
            w_addr  = 28'h0000ABC;
            w_req   = 5'd20;
            w_sh    = 16'hFFFF;
            w_valid = 1'b1;
            tick();
            w_valid = 1'b0;
            for (int i = 0; i < 16; i++) begin
                chk("w_valid", 32'(w_ovalid), 32'd1);
                chk("w_dest", 32'(w_odest), 32'(i));
                tick();
            end
            chk("w_done", 32'(w_done), 32'd1);
            chk("w_inv_cnt", 32'(w_inv), 32'd16);
        end

`ifdef LLC_FWD_SEQ_STATS_EN
        chk("stats_sent", 32'(sent_cnt), 32'd20);
        chk("stats_stall", 32'(stall_cnt), 32'd4);
        chk("w_stats_sent", 32'(w_sent), 32'd16);
`endif

        send_cmd(M_INV, 28'h0000100, 4'd0, 4'd0, 16'h00F0);
        chk("ab_dest0", 32'(o_dest), 32'd4);
        tick();
        chk("ab_dest1", 32'(o_dest), 32'd5);
        tick();
        chk("ab_dest2", 32'(o_dest), 32'd6);
`ifdef LLC_FWD_SEQ_STATS_EN
        chk("ab_sent_pre", 32'(sent_cnt), 32'd22);
`endif
        rst = 1'b0;
        #1;
        chk("ab_valid", 32'(o_valid), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_cready", 32'(c_ready), 32'd0);
`ifdef LLC_FWD_SEQ_STATS_EN
        chk("ab_sent_rst", 32'(sent_cnt), 32'd0);
        chk("ab_stall_rst", 32'(stall_cnt), 32'd0);
`endif
        tick();
        tick();
        chk("ab_hold_valid", 32'(o_valid), 32'd0);
        chk("ab_hold_done", 32'(done), 32'd0);
        rst = 1'b1;
        tick();
        chk("ab_valid_after", 32'(o_valid), 32'd0);
        chk("ab_done_after", 32'(done), 32'd0);

        send_cmd(M_GETS, 28'h0000200, 4'd1, 4'd3, 16'h0000);
        expect_seq("post_ab", 16'h0008, 0, M_GETS, 4'd1, 28'h0000200);
`ifdef LLC_FWD_SEQ_STATS_EN
        chk("post_sent", 32'(sent_cnt), 32'd1);
        chk("post_stall", 32'(stall_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
